// File: rtl/ddr2_phy_lane_seq.sv
// DDR2 data-lane sequencer: turns single-cycle write/read burst starts into
// registered pad controls (DQ/DQS/DQS#/DM, TS, RI) and read-data capture.
// Ports:
//   clk, reset            clock and async active-high reset
//   wr_start, rd_start    burst requests
//   wl, rl                write/read latency
//   wr_data, wr_mask      write beat and byte mask, taken on data_req
//   data_req              write beat request, one cycle ahead of drive
//   busy, cmd_drop        burst in progress / start ignored pulse
//   ts_o, ri_o            pad output enable / receive enable
//   dq_o, dqs_o           pad data and strobe drive
//   dqsbar_o, dm_o        inverted strobe and mask drive
//   dq_i                  pad receive data
//   rd_data, rd_valid     captured read beat
module ddr2_phy_lane_seq #(
  parameter int DQ_WIDTH  = 16,
  parameter int DQS_WIDTH = DQ_WIDTH / 8,
  parameter int BL        = 4,
  parameter int LAT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_start,
  input  logic                 rd_start,
  input  logic [LAT_W-1:0]     wl,
  input  logic [LAT_W-1:0]     rl,
  input  logic [DQ_WIDTH-1:0]  wr_data,
  input  logic [DQS_WIDTH-1:0] wr_mask,
  output logic                 data_req,
  output logic                 busy,
  output logic                 cmd_drop,
  output logic                 ts_o,
  output logic                 ri_o,
  output logic [DQ_WIDTH-1:0]  dq_o,
  output logic [DQS_WIDTH-1:0] dqs_o,
  output logic [DQS_WIDTH-1:0] dqsbar_o,
  output logic [DQS_WIDTH-1:0] dm_o,
  input  logic [DQ_WIDTH-1:0]  dq_i,
  output logic [DQ_WIDTH-1:0]  rd_data,
  output logic                 rd_valid
);

  localparam int LMAX = 1 << LAT_W;
  localparam int SPAN = (BL > LMAX) ? BL : LMAX;
  localparam int CW   = (SPAN > 2) ? $clog2(SPAN) : 1;

  localparam logic [CW-1:0] ONE  = 1;
  localparam logic [CW-1:0] LAST = CW'(BL - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_PRE,
    WR_BURST,
    WR_POST,
    RD_WAIT,
    RD_BURST
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  logic ts_n;
  logic ri_n;
  logic req_n;
  logic busy_n;
  logic drop_n;
  logic dqs_n;

  // Latency phases count down from lat-1 to 0; burst phases count
  // beats up from 0 to BL-1. The same counter serves both.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (wr_start) begin
          state_n = (wl == '0) ? WR_PRE : WR_WAIT;
          cnt_n   = CW'(wl) - ONE;
        end else if (rd_start) begin
          state_n = (rl == '0) ? RD_BURST : RD_WAIT;
          cnt_n   = (rl == '0) ? '0 : CW'(rl) - ONE;
        end
      end
      WR_WAIT: begin
        if (cnt == '0) state_n = WR_PRE;
        else           cnt_n   = cnt - ONE;
      end
      WR_PRE: begin
        state_n = WR_BURST;
        cnt_n   = '0;
      end
      WR_BURST: begin
        if (cnt == LAST) state_n = WR_POST;
        else             cnt_n   = cnt + ONE;
      end
      WR_POST: begin
        state_n = IDLE;
      end
      RD_WAIT: begin
        if (cnt == '0) state_n = RD_BURST;
        else           cnt_n   = cnt - ONE;
      end
      RD_BURST: begin
        if (cnt == LAST) state_n = IDLE;
        else             cnt_n   = cnt + ONE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered,
  // they line up with the state they describe.
  always_comb begin
    ts_n   = (state_n == WR_PRE) || (state_n == WR_BURST) ||
             (state_n == WR_POST);
    ri_n   = (state_n == RD_BURST);
    busy_n = (state_n != IDLE);
    req_n  = (state_n == WR_PRE) ||
             ((state_n == WR_BURST) && (cnt_n != LAST));
    dqs_n  = (state_n == WR_BURST) && !cnt_n[0];
    drop_n = (state != IDLE) ? (wr_start | rd_start)
                             : (wr_start & rd_start);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ts_o     <= 1'b0;
      ri_o     <= 1'b0;
      busy     <= 1'b0;
      data_req <= 1'b0;
      cmd_drop <= 1'b0;
      dqs_o    <= '0;
      dq_o     <= '0;
      dm_o     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ts_o     <= ts_n;
      ri_o     <= ri_n;
      busy     <= busy_n;
      data_req <= req_n;
      cmd_drop <= drop_n;
      dqs_o    <= {DQS_WIDTH{dqs_n}};
      // Beat taken in a data_req cycle drives the pads next cycle;
      // the last beat is held through the postamble.
      if (data_req) begin
        dq_o <= wr_data;
        dm_o <= wr_mask;
      end
      rd_valid <= (state == RD_BURST);
      if (state == RD_BURST) rd_data <= dq_i;
    end
  end

  assign dqsbar_o = ~dqs_o;

endmodule

// File: doc/ddr2_phy_lane_seq.md
# ddr2_phy_lane_seq

Parametrised DDR2 data-lane sequencer between the controller core and the SSTL18 pad ring. Converts single-cycle write/read burst starts into cycle-accurate pad control: DQ/DQS/DQS#/DM drive values, the TS (output enable) and RI (receive enable) strobes, write preamble/postamble, write/read latency counting and registered read-data capture. Unlike the static pad wrapper, it owns the bidirectional turnaround timing and scales in DQ width and burst length.

## Interface
Parameters:
- DQ_WIDTH, 16, data bits; must be a multiple of 8
- DQS_WIDTH, DQ_WIDTH/8, strobe/mask lanes (one per byte)
- BL, 4, burst length in beats (4 or 8; one beat per clk)
- LAT_W, 4, width of the wl/rl latency inputs

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- wr_start  in  1  single-cycle write burst request
- rd_start  in  1  single-cycle read burst request
- wl  in  LAT_W  write latency in clk cycles, sampled with wr_start
- rl  in  LAT_W  read latency in clk cycles, sampled with rd_start
- wr_data  in  DQ_WIDTH  write beat, sampled when data_req=1
- wr_mask  in  DQS_WIDTH  per-byte mask, sampled with wr_data
- data_req  out  1  write beat request (one cycle ahead of drive)
- busy  out  1  burst in progress; starts ignored
- cmd_drop  out  1  one-cycle pulse: a start was ignored
- ts_o  out  1  pad output enable for DQ/DQS/DQS# (1 = drive)
- ri_o  out  1  pad receive enable
- dq_o  out  DQ_WIDTH  to pad A inputs
- dqs_o  out  DQS_WIDTH  strobe drive, all lanes identical
- dqsbar_o  out  DQS_WIDTH  always ~dqs_o
- dm_o  out  DQS_WIDTH  mask drive
- dq_i  in  DQ_WIDTH  from pad Z outputs
- rd_data  out  DQ_WIDTH  captured read beat
- rd_valid  out  1  rd_data valid this cycle

## Operation
- States: IDLE, WR_WAIT, WR_PRE, WR_BURST, WR_POST, RD_WAIT, RD_BURST. One beat counter (clog2(max(BL,2^LAT_W)) bits) reused for latency and beats.
- IDLE: wr_start -> WR_WAIT (wl=0 -> WR_PRE directly); rd_start -> RD_WAIT (rl=0 -> RD_BURST). Both asserted: write taken, cmd_drop pulses.
- WR_WAIT: wl cycles, ts_o=0. WR_PRE: 1 cycle, ts_o=1, dqs_o=0. WR_BURST: BL cycles, ts_o=1, dqs_o toggles starting at 1 on beat 0. WR_POST: 1 cycle, ts_o=1, dqs_o=0, dq_o holds last beat. Then IDLE.
- data_req is high in the cycle before each of the BL burst beats; beat k drives the wr_data/wr_mask sampled in the k-th data_req cycle.
- RD_WAIT: rl cycles. RD_BURST: BL cycles, ri_o=1, ts_o=0; dq_i registered to rd_data each cycle, rd_valid one cycle later. Then IDLE.
- busy=1 in every state except IDLE. wr_start/rd_start while busy: ignored, cmd_drop=1 next cycle.
- All outputs registered. dqsbar_o=~dqs_o at all times, including reset.

## Timing
- Reset (async assert, sync release): state IDLE; ts_o=0, ri_o=0, dq_o=0, dqs_o=0, dqsbar_o=all 1, dm_o=0, data_req=0, busy=0, cmd_drop=0, rd_data=0, rd_valid=0. Reset mid-burst releases the bus immediately (ts_o=0 asynchronously).
- Write, wr_start in cycle 0: WR_WAIT cycles 1..wl; WR_PRE cycle wl+1; beats cycles wl+2..wl+1+BL; WR_POST cycle wl+2+BL; IDLE and new start accepted cycle wl+3+BL. data_req cycles wl+1..wl+BL.
- Read, rd_start in cycle 0: ri_o high cycles rl+1..rl+BL; rd_valid cycles rl+2..rl+BL+1; IDLE cycle rl+BL+1 (start accepted while last rd_valid still high).
- Write-after-read back-to-back: ts_o never high in a cycle where ri_o is high.

## Test plan
- Reset during WR_BURST beat 2 -> ts_o=0 same cycle, dqsbar_o=all 1, state IDLE, busy=0 after release.
- wr_start, wl=3, BL=4, data 0x1111..0x4444 -> data_req cycles 4-7, ts_o cycles 4-9, dq_o 0x1111..0x4444 cycles 5-8, dqs_o 1,0,1,0, busy low cycle 10.
- rd_start, rl=5, dq_i driven 0xA5A5,0x5A5A,0xFFFF,0x0000 in cycles 6-9 -> rd_valid cycles 7-10 with matching rd_data, ri_o cycles 6-9.
- wr_start and rd_start together in IDLE -> write executes, cmd_drop=1 in cycle 1, no ri_o.
- rd_start during active write -> ignored, cmd_drop pulse, write sequence unchanged.
- BL=8, DQ_WIDTH=32, wl=0 -> WR_PRE cycle 1, 8 beats cycles 2-9, dqs_o/dm_o 4 lanes identical, wr_mask 4'b0101 reflected on dm_o.
